// File: rtl/field_pkg.sv
// Shared types and defaults for the field classifier stage.
package field_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CALIB    = 2'd1,
    ST_CLASSIFY = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  localparam int FIELD_W   = 32;
  localparam int LABEL_W   = 8;
  localparam int LABEL_MIN = 1;

endpackage

// File: rtl/field_classifier_if.sv
// Config, sample and label streams of the field classifier.
interface field_classifier_if
  import field_pkg::*;
#(
  parameter int FIELD_WIDTH = FIELD_W,
  parameter int LABEL_WIDTH = LABEL_W,
  parameter int CNT_WIDTH   = 32
);
  logic [CNT_WIDTH-1:0]   s_cfg_count;
  logic                   s_cfg_valid;
  logic                   s_cfg_ready;
  logic [FIELD_WIDTH-1:0] s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic [LABEL_WIDTH-1:0] m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic                   busy;

  modport master (
    output s_cfg_count, s_cfg_valid, s_tdata, s_tvalid, m_tready,
    input  s_cfg_ready, s_tready, m_tdata, m_tvalid, m_tlast, busy
  );

  modport slave (
    input  s_cfg_count, s_cfg_valid, s_tdata, s_tvalid, m_tready,
    output s_cfg_ready, s_tready, m_tdata, m_tvalid, m_tlast, busy
  );
endinterface

// File: rtl/field_label_enc.sv
// First-match priority comparator: smallest i with x <= thr[i] gives LAY_NUM+1-i, else 1.
module field_label_enc
  import field_pkg::*;
#(
  parameter int FIELD_WIDTH = FIELD_W,
  parameter int LAY_NUM     = 2,
  parameter int LABEL_WIDTH = LABEL_W
) (
  input  logic [FIELD_WIDTH-1:0]              x_i,
  input  logic [LAY_NUM-1:0][FIELD_WIDTH-1:0] thr_i,
  output logic [LABEL_WIDTH-1:0]              label_o
);

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    label_o = LABEL_WIDTH'(LABEL_MIN);
    for (int i = LAY_NUM - 1; i >= 0; i--) begin
      if ($signed(x_i) <= $signed(thr_i[i])) begin
        label_o = LABEL_WIDTH'(LAY_NUM + LABEL_MIN - i);
      end
    end
  end

endmodule

// File: rtl/field_classifier.sv
// Frame-based threshold classifier; FIELD_CLASSIFIER_SORT_EN keeps thresholds sorted during CALIB.
//
// state    | meaning
// IDLE     | waiting for a cfg handshake
// CALIB    | first LAY_NUM samples become thresholds
// CLASSIFY | each sample labelled into the output register
// DRAIN    | waiting for the final label to handshake
module field_classifier
  import field_pkg::*;
#(
  parameter int FIELD_WIDTH = FIELD_W,
  parameter int LABEL_WIDTH = LABEL_W,
  parameter int LAY_NUM     = 2,
  parameter int CNT_WIDTH   = 32
) (
  input logic               aclk,
  input logic               aresetn,
  field_classifier_if.slave bus
);

  localparam int IDX_W = $clog2(LAY_NUM + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAY_NUM - 1);

  state_e                              state_q;
  logic [CNT_WIDTH-1:0]                cnt_q;
  logic [CNT_WIDTH-1:0]                samp_q;
  logic [IDX_W-1:0]                    idx_q;
  logic [LAY_NUM-1:0][FIELD_WIDTH-1:0] thr_q;
  logic [LAY_NUM-1:0][FIELD_WIDTH-1:0] thr_d;
  logic [LABEL_WIDTH-1:0]              m_tdata_q;
  logic                                m_tvalid_q;
  logic                                m_tlast_q;
  logic [LABEL_WIDTH-1:0]              label;
  logic                                s_tready;
  logic                                s_acc;
  logic                                m_hs;
  logic                                last_samp;

  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      ST_CALIB:    s_tready = 1'b1;
      ST_CLASSIFY: s_tready = !m_tvalid_q || bus.m_tready;
      default:     s_tready = 1'b0;
    endcase
  end

  assign s_acc     = bus.s_tvalid && s_tready;
  assign m_hs      = m_tvalid_q && bus.m_tready;
  assign last_samp = (samp_q == cnt_q - CNT_WIDTH'(1));

`ifdef FIELD_CLASSIFIER_SORT_EN
  logic                   le_cur;
  logic                   ins_prev;
  logic [FIELD_WIDTH-1:0] thr_prev;

  // Entries [0, idx) are sorted; slot i keeps, takes x, or takes its lower neighbour.
  always_comb begin
    thr_d    = thr_q;
    le_cur   = 1'b0;
    ins_prev = 1'b1;
    thr_prev = '0;
    for (int i = 0; i < LAY_NUM; i++) begin
      le_cur = (IDX_W'(i) < idx_q) && ($signed(thr_q[i]) <= $signed(bus.s_tdata));
      if ((IDX_W'(i) <= idx_q) && !le_cur) begin
        thr_d[i] = ins_prev ? bus.s_tdata : thr_prev;
      end
      ins_prev = le_cur;
      thr_prev = thr_q[i];
    end
  end
`else
  always_comb begin
    thr_d = thr_q;
    for (int i = 0; i < LAY_NUM; i++) begin
      if (IDX_W'(i) == idx_q) thr_d[i] = bus.s_tdata;
    end
  end
`endif

  field_label_enc #(
    .FIELD_WIDTH (FIELD_WIDTH),
    .LAY_NUM     (LAY_NUM),
    .LABEL_WIDTH (LABEL_WIDTH)
  ) u_label_enc (
    .x_i     (bus.s_tdata),
    .thr_i   (thr_q),
    .label_o (label)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      samp_q     <= '0;
      idx_q      <= '0;
      thr_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      if (m_hs) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.s_cfg_valid) begin
            cnt_q   <= bus.s_cfg_count;
            samp_q  <= '0;
            idx_q   <= '0;
            state_q <= ST_CALIB;
          end
        end
        ST_CALIB: begin
          if (s_acc) begin
            thr_q <= thr_d;
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_q <= (cnt_q == '0) ? ST_IDLE : ST_CLASSIFY;
            end
          end
        end
        ST_CLASSIFY: begin
          // A same-cycle output handshake is overridden by the reload here.
          if (s_acc) begin
            m_tdata_q  <= label;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= last_samp;
            samp_q     <= samp_q + CNT_WIDTH'(1);
            if (last_samp) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (m_hs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_cfg_ready = (state_q == ST_IDLE);
  assign bus.s_tready    = s_tready;
  assign bus.m_tdata     = m_tdata_q;
  assign bus.m_tvalid    = m_tvalid_q;
  assign bus.m_tlast     = m_tlast_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_field_classifier.sv
// Directed bench: LAY_NUM=2 instance for most scenarios, LAY_NUM=3 instance for threshold ordering.
module tb_field_classifier;

  logic clk;
  logic rst_n;

  field_classifier_if #(.FIELD_WIDTH(32), .LABEL_WIDTH(8), .CNT_WIDTH(32)) if2 ();
  field_classifier_if #(.FIELD_WIDTH(32), .LABEL_WIDTH(8), .CNT_WIDTH(32)) if3 ();

  field_classifier #(.FIELD_WIDTH(32), .LABEL_WIDTH(8), .LAY_NUM(2), .CNT_WIDTH(32)) u_dut2 (
    .aclk    (clk),
    .aresetn (rst_n),
    .bus     (if2)
  );

  field_classifier #(.FIELD_WIDTH(32), .LABEL_WIDTH(8), .LAY_NUM(3), .CNT_WIDTH(32)) u_dut3 (
    .aclk    (clk),
    .aresetn (rst_n),
    .bus     (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cal_q[$];
  logic [31:0] smp_q[$];
  logic [7:0]  lab_q[$];
  logic        lst_q[$];
  int first_valid, first_acc, valid_cycles, stall_viol, timed_out, last_hs;

  // Drives one frame on if2; rdy_mode 0 = always ready, 1 = pattern 1,0,0,1.
  task automatic run_frame2(input logic [31:0] cnt, input int rdy_mode, input int stop_after);
    logic [31:0] all_q[$];
    int ptr, ncal, cyc;
    logic prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    bit done;
    all_q.delete();
    foreach (cal_q[i]) all_q.push_back(cal_q[i]);
    foreach (smp_q[i]) all_q.push_back(smp_q[i]);
    ncal = cal_q.size();
    lab_q.delete(); lst_q.delete();
    first_valid = -1; first_acc = -1; valid_cycles = 0; stall_viol = 0; timed_out = 0; last_hs = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; ptr = 0; done = 1'b0;
    @(negedge clk);
    if2.s_cfg_count = cnt;
    if2.s_cfg_valid = 1'b1;
    @(negedge clk);
    if2.s_cfg_valid = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (ptr < all_q.size()) begin
        if2.s_tvalid = 1'b1;
        if2.s_tdata  = all_q[ptr];
      end else begin
        if2.s_tvalid = 1'b0;
        if2.s_tdata  = '0;
      end
      if2.m_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (if2.m_tvalid && !if2.m_tready && if2.s_tready) stall_viol++;
      if (prev_stall && (!if2.m_tvalid || if2.m_tdata !== prev_data || if2.m_tlast !== prev_last))
        stall_viol++;
      prev_stall = if2.m_tvalid && !if2.m_tready;
      prev_data  = if2.m_tdata;
      prev_last  = if2.m_tlast;
      if (if2.m_tvalid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (if2.m_tvalid && if2.m_tready) begin
        lab_q.push_back(if2.m_tdata);
        lst_q.push_back(if2.m_tlast);
        last_hs = cyc;
      end
      if (if2.s_tvalid && if2.s_tready) begin
        if (ptr == ncal) first_acc = cyc;
        ptr++;
      end
      if (stop_after > 0 && lab_q.size() == stop_after) begin
        done = 1'b1;
        break;
      end
      if (ptr == all_q.size() && lab_q.size() == smp_q.size()) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) timed_out = 1;
    if (stop_after == 0) begin
      @(negedge clk);
      if2.s_tvalid = 1'b0;
      if2.m_tready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (if2.m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", if2.m_tvalid); end
    n_cmp++; if (if2.m_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", if2.m_tlast); end
    n_cmp++; if (if2.m_tdata !== 8'd0) begin n_err++; $display("FAIL reset_tdata got %0d want 0", if2.m_tdata); end
    n_cmp++; if (if2.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", if2.busy); end
    n_cmp++; if (if2.s_cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b want 1", if2.s_cfg_ready); end
    n_cmp++; if (if2.s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready got %b want 0", if2.s_tready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_legacy(input string tag);
    logic [7:0] exp_lab[4];
    logic       exp_lst[4];
    exp_lab = '{8'd3, 8'd3, 8'd2, 8'd1};
    exp_lst = '{1'b0, 1'b0, 1'b0, 1'b1};
    n_cmp++; if (timed_out !== 0) begin n_err++; $display("FAIL %s_timeout got %0d want 0", tag, timed_out); end
    n_cmp++; if (lab_q.size() !== 4) begin n_err++; $display("FAIL %s_nlabels got %0d want 4", tag, lab_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < lab_q.size()) begin
        n_cmp++;
        if (lab_q[i] !== exp_lab[i] || lst_q[i] !== exp_lst[i]) begin
          n_err++;
          $display("FAIL %s_label%0d got %0d/last%b want %0d/last%b", tag, i, lab_q[i], lst_q[i], exp_lab[i], exp_lst[i]);
        end
      end
    end
  endtask

  task automatic test_legacy();
    cal_q = '{32'd100, 32'd200};
    smp_q = '{32'd50, 32'd100, 32'd150, 32'd300};
    run_frame2(32'd4, 0, 0);
    check_legacy("legacy");
    n_cmp++; if (first_valid !== first_acc + 1) begin n_err++; $display("FAIL legacy_latency got valid@%0d want %0d", first_valid, first_acc + 1); end
    n_cmp++; if (valid_cycles !== 4) begin n_err++; $display("FAIL legacy_valid_cycles got %0d want 4", valid_cycles); end
    n_cmp++; if (last_hs !== first_valid + 3) begin n_err++; $display("FAIL legacy_b2b got last@%0d want %0d", last_hs, first_valid + 3); end
    #1;
    n_cmp++; if (if2.busy !== 1'b0 || if2.s_cfg_ready !== 1'b1) begin n_err++; $display("FAIL legacy_idle got busy%b rdy%b want busy0 rdy1", if2.busy, if2.s_cfg_ready); end
  endtask

  task automatic test_backpressure();
    cal_q = '{32'd100, 32'd200};
    smp_q = '{32'd50, 32'd100, 32'd150, 32'd300};
    run_frame2(32'd4, 1, 0);
    check_legacy("bp");
    n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL bp_stall_rules got %0d violations want 0", stall_viol); end
    n_cmp++; if (valid_cycles <= 4) begin n_err++; $display("FAIL bp_stalled got %0d valid cycles want >4", valid_cycles); end
  endtask

  task automatic test_zero_count();
    int tv;
    tv = 0;
    @(negedge clk);
    if2.s_cfg_count = 32'd0;
    if2.s_cfg_valid = 1'b1;
    @(negedge clk);
    if2.s_cfg_valid = 1'b0;
    if2.s_tvalid = 1'b1;
    if2.s_tdata  = 32'd7;
    #1;
    n_cmp++; if (if2.s_tready !== 1'b1 || if2.s_cfg_ready !== 1'b0) begin n_err++; $display("FAIL zero_calib got trdy%b crdy%b want 1/0", if2.s_tready, if2.s_cfg_ready); end
    if (if2.m_tvalid) tv++;
    @(negedge clk);
    if2.s_tdata = 32'd9;
    #1;
    if (if2.m_tvalid) tv++;
    @(negedge clk);
    if2.s_tvalid = 1'b0;
    #1;
    n_cmp++; if (if2.s_cfg_ready !== 1'b1 || if2.busy !== 1'b0) begin n_err++; $display("FAIL zero_idle got crdy%b busy%b want 1/0", if2.s_cfg_ready, if2.busy); end
    for (int i = 0; i < 3; i++) begin
      if (if2.m_tvalid) tv++;
      @(negedge clk);
      #1;
    end
    n_cmp++; if (tv !== 0) begin n_err++; $display("FAIL zero_no_output got %0d valid cycles want 0", tv); end
  endtask

  task automatic test_unsorted();
    logic [31:0] seq[4];
    logic [7:0] got, exp_lab;
    logic got_last;
    int ptr, nlab;
    seq = '{32'd300, -32'sd100, 32'd0, 32'd5};
`ifdef FIELD_CLASSIFIER_SORT_EN
    exp_lab = 8'd2;
`else
    exp_lab = 8'd4;
`endif
    ptr = 0; nlab = 0; got = '0; got_last = 1'b0;
    @(negedge clk);
    if3.s_cfg_count = 32'd1;
    if3.s_cfg_valid = 1'b1;
    @(negedge clk);
    if3.s_cfg_valid = 1'b0;
    if3.m_tready = 1'b1;
    for (int cyc = 0; cyc < 40 && nlab == 0; cyc++) begin
      if3.s_tvalid = (ptr < 4);
      if3.s_tdata  = (ptr < 4) ? seq[ptr] : 32'd0;
      #1;
      if (if3.m_tvalid && if3.m_tready) begin
        got = if3.m_tdata; got_last = if3.m_tlast; nlab++;
      end
      if (if3.s_tvalid && if3.s_tready) ptr++;
      @(negedge clk);
    end
    if3.s_tvalid = 1'b0;
    n_cmp++; if (nlab !== 1) begin n_err++; $display("FAIL unsorted_count got %0d want 1", nlab); end
    n_cmp++; if (got !== exp_lab || got_last !== 1'b1) begin n_err++; $display("FAIL unsorted_label got %0d/last%b want %0d/last1", got, got_last, exp_lab); end
  endtask

  task automatic test_mid_reset();
    cal_q = '{32'd100, 32'd200};
    smp_q = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    run_frame2(32'd5, 0, 2);
    n_cmp++; if (lab_q.size() !== 2 || lab_q[0] !== 8'd3 || lab_q[1] !== 8'd3) begin n_err++; $display("FAIL midrst_prefix got %0d labels want 2 of label 3", lab_q.size()); end
    @(posedge clk);
    #2;
    n_cmp++; if (if2.busy !== 1'b1 || if2.m_tvalid !== 1'b1) begin n_err++; $display("FAIL midrst_pre got busy%b valid%b want 1/1", if2.busy, if2.m_tvalid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if2.m_tvalid !== 1'b0 || if2.busy !== 1'b0) begin n_err++; $display("FAIL midrst_async got valid%b busy%b want 0/0", if2.m_tvalid, if2.busy); end
    n_cmp++; if (if2.m_tlast !== 1'b0 || if2.m_tdata !== 8'd0) begin n_err++; $display("FAIL midrst_outreg got last%b data%0d want 0/0", if2.m_tlast, if2.m_tdata); end
    @(negedge clk);
    if2.s_tvalid = 1'b0;
    if2.m_tready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cal_q = '{32'd100, 32'd200};
    smp_q = '{32'd50, 32'd100, 32'd150, 32'd300};
    run_frame2(32'd4, 0, 0);
    check_legacy("postrst");
    n_cmp++; if (first_valid !== first_acc + 1) begin n_err++; $display("FAIL postrst_latency got valid@%0d want %0d", first_valid, first_acc + 1); end
  endtask

  task automatic test_signed_boundary();
    cal_q = '{32'h8000_0000, 32'h0000_0000};
    smp_q = '{32'h8000_0000, 32'h7FFF_FFFF};
    run_frame2(32'd2, 0, 0);
    n_cmp++; if (timed_out !== 0 || lab_q.size() !== 2) begin n_err++; $display("FAIL signed_count got %0d labels timeout%0d want 2/0", lab_q.size(), timed_out); end
    if (lab_q.size() == 2) begin
      n_cmp++; if (lab_q[0] !== 8'd3) begin n_err++; $display("FAIL signed_min got %0d want 3", lab_q[0]); end
      n_cmp++; if (lab_q[1] !== 8'd1 || lst_q[1] !== 1'b1) begin n_err++; $display("FAIL signed_max got %0d/last%b want 1/last1", lab_q[1], lst_q[1]); end
    end
  endtask

  initial begin
    if2.s_cfg_count = '0; if2.s_cfg_valid = 1'b0; if2.s_tdata = '0; if2.s_tvalid = 1'b0; if2.m_tready = 1'b1;
    if3.s_cfg_count = '0; if3.s_cfg_valid = 1'b0; if3.s_tdata = '0; if3.s_tvalid = 1'b0; if3.m_tready = 1'b1;
    test_reset();
    test_legacy();
    test_backpressure();
    test_zero_count();
    test_unsorted();
    test_mid_reset();
    test_signed_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
